tri_job_sched: RTL and testbench

//   Two-requester scheduler for the 3-bit triangle rasterizer (nt/xi/yi in; busy/po/xo/yo out).

---
 rtl/tri_pkg.sv | 40 ++++
 rtl/tri_job_sched_if.sv | 43 ++++
 rtl/rr_arb2.sv | 20 ++
 rtl/tri_job_sched.sv | 129 ++++++++++++
 tb/tb_tri_job_sched.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/tri_pkg.sv
// Shared types and constants for the triangle job scheduler and rasterizer bench models.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tri_pkg;

  localparam int COORD_W = 3;
  localparam int TRI_W   = 6 * COORD_W;   // {x1,y1,x2,y2,x3,y3}, x1 in the top bits
  localparam int CNT_W   = 7;
  localparam int WDOG_W  = 8;

  // Field offsets (lsb) inside a packed triangle word
  localparam int X1_OFF = 15;
  localparam int Y1_OFF = 12;
  localparam int X2_OFF = 9;
  localparam int Y2_OFF = 6;
  localparam int X3_OFF = 3;
  localparam int Y3_OFF = 0;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD1     = 3'd1,
    LOAD2     = 3'd2,
    LOAD3     = 3'd3,
    WAIT_BUSY = 3'd4,
    RUN       = 3'd5,
    DONE      = 3'd6
  } state_t;

  typedef struct packed {
    logic               id;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } pix_t;

  // Vertex idx (0..2) of a packed triangle as {x,y}
  function automatic logic [2*COORD_W-1:0] vtx(input logic [TRI_W-1:0] t, input int unsigned idx);
    return t[TRI_W-1-2*COORD_W*idx -: 2*COORD_W];
  endfunction

endpackage

// File: rtl/tri_job_sched_if.sv
// Job-source, rasterizer and result signals of the triangle scheduler.
// Latency: n/a (wiring only).
// Backpressure: req held until ack; rasterizer paced by its busy line.
// master = scheduler side, slave = job sources / rasterizer / result sink.
// Triangle words are named tri_0/tri_1 because tri0/tri1 are SystemVerilog net-type keywords.
interface tri_job_sched_if;
  import tri_pkg::*;

  logic               req0;
  logic [TRI_W-1:0]   tri_0;
  logic               ack0;
  logic               req1;
  logic [TRI_W-1:0]   tri_1;
  logic               ack1;
  logic               nt;
  logic [COORD_W-1:0] xi;
  logic [COORD_W-1:0] yi;
  logic               busy;
  logic               po;
  logic [COORD_W-1:0] xo;
  logic [COORD_W-1:0] yo;
  logic               pix_valid;
  logic               pix_id;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic               done;
  logic               done_id;
  logic [CNT_W-1:0]   done_cnt;
  logic               err;

  modport master (
    input  req0, tri_0, req1, tri_1, busy, po, xo, yo,
    output ack0, ack1, nt, xi, yi, pix_valid, pix_id, pix_x, pix_y,
           done, done_id, done_cnt, err
  );

  modport slave (
    output req0, tri_0, req1, tri_1, busy, po, xo, yo,
    input  ack0, ack1, nt, xi, yi, pix_valid, pix_id, pix_x, pix_y,
           done, done_id, done_cnt, err
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last time gets the grant.
// Latency: combinational.
// Backpressure: grant_en low forces gnt to zero.
// Ports: req[1:0] requests, grant_en qualifier, last = id granted last time, gnt[1:0] one-hot grant.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       grant_en,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (grant_en) begin
      if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

endmodule

// File: rtl/tri_job_sched.sv
// Round-robin job scheduler in front of one triangle rasterizer, with pixel forwarding and watchdog.
// Latency: ack same cycle as grant in IDLE; vertices 1 cycle after ack; pixels 1 cycle after po; done 2 cycles after last busy.
// Backpressure: no grant while the rasterizer is busy; requests hold until ack.
// Ports: clk, reset (sync, active high); bus = master side of tri_job_sched_if (requesters, rasterizer, results).
module tri_job_sched
  import tri_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input logic             clk,
  input logic             reset,
  tri_job_sched_if.master bus
);

  state_t             state, state_nxt;
  logic [TRI_W-1:0]   tri_q;
  logic               job_id;
  logic               last_grant;
  logic [CNT_W-1:0]   cnt;
  logic [WDOG_W-1:0]  wdog;
  logic               abort_q;
  pix_t               pix_q;
  logic               pix_valid_q;
  logic [1:0]         gnt;
  logic               grant;
  logic               active;
  logic               wdog_exp;
  logic               take_pix;

  assign active   = (state == WAIT_BUSY) || (state == RUN);
  assign wdog_exp = (wdog == WDOG_W'(TIMEOUT_CYC - 1));
  assign take_pix = active && bus.po;

  // After an abort the rasterizer may still be draining, so busy also gates grants here.
  rr_arb2 u_arb (
    .req      ({bus.req1, bus.req0}),
    .grant_en ((state == IDLE) && !bus.busy && !reset),
    .last     (last_grant),
    .gnt      (gnt)
  );

  assign grant = |gnt;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state; watchdog expiry wins over the busy handshake
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (grant) state_nxt = LOAD1;
      LOAD1:     state_nxt = LOAD2;
      LOAD2:     state_nxt = LOAD3;
      LOAD3:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (wdog_exp) state_nxt = DONE;
                 else if (bus.busy) state_nxt = RUN;
      RUN:       if (wdog_exp || !bus.busy) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Job context, pixel register, counter and watchdog
  always_ff @(posedge clk) begin
    if (reset) begin
      tri_q       <= '0;
      job_id      <= 1'b0;
      last_grant  <= 1'b1;
      cnt         <= '0;
      wdog        <= '0;
      abort_q     <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_q       <= '0;
    end else begin
      pix_valid_q <= take_pix;
      pix_q       <= take_pix ? pix_t'{id: job_id, x: bus.xo, y: bus.yo} : '0;
      if (grant) begin
        tri_q      <= gnt[1] ? bus.tri_1 : bus.tri_0;
        job_id     <= gnt[1];
        last_grant <= gnt[1];
        cnt        <= '0;
        wdog       <= '0;
        abort_q    <= 1'b0;
      end
      if (active) begin
        wdog <= wdog + WDOG_W'(1);
        if (wdog_exp) abort_q <= 1'b1;
        if (bus.po && (cnt != '1)) cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_id    = pix_q.id;
  assign bus.pix_x     = pix_q.x;
  assign bus.pix_y     = pix_q.y;

  // Outputs decoded from registered state
  always_comb begin
    bus.ack0     = gnt[0];
    bus.ack1     = gnt[1];
    bus.nt       = 1'b0;
    bus.xi       = '0;
    bus.yi       = '0;
    bus.done     = 1'b0;
    bus.done_id  = 1'b0;
    bus.done_cnt = '0;
    bus.err      = 1'b0;
    unique case (state)
      LOAD1: begin
        bus.nt = 1'b1;
        {bus.xi, bus.yi} = vtx(tri_q, 0);
      end
      LOAD2: {bus.xi, bus.yi} = vtx(tri_q, 1);
      LOAD3: {bus.xi, bus.yi} = vtx(tri_q, 2);
      DONE: begin
        bus.done     = 1'b1;
        bus.done_id  = job_id;
        bus.done_cnt = cnt;
        bus.err      = abort_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tri_job_sched.sv
// Bench for tri_job_sched: behavioural rasterizer, pixel/done scoreboards, directed scenarios.
module tb_tri_job_sched;
  import tri_pkg::*;

  localparam int TO = 20;
  localparam logic [17:0] T_A = {3'd0, 3'd0, 3'd0, 3'd3, 3'd3, 3'd3};
  localparam logic [17:0] T_B = {3'd4, 3'd4, 3'd7, 3'd4, 3'd7, 3'd7};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tri_job_sched_if bus ();

  tri_job_sched #(.TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [6:0] exp_pix[$];   // {id,x,y}
  logic [8:0] exp_done[$];  // {id,cnt,err}
  logic [6:0] ep;
  logic [8:0] ed;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  // Pixel coverage: all three edge functions share a sign (edges inclusive)
  function automatic bit in_tri(input logic [17:0] t, input int px, input int py);
    int ax, ay, bx, by, cx, cy, e0, e1, e2;
    ax = int'(t[17:15]); ay = int'(t[14:12]);
    bx = int'(t[11:9]);  by = int'(t[8:6]);
    cx = int'(t[5:3]);   cy = int'(t[2:0]);
    e0 = (bx - ax) * (py - ay) - (by - ay) * (px - ax);
    e1 = (cx - bx) * (py - by) - (cy - by) * (px - bx);
    e2 = (ax - cx) * (py - cy) - (ay - cy) * (px - cx);
    return (e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0);
  endfunction

  // Output monitor: pops scoreboards when the DUT emits pixels / done
  always @(negedge clk) begin
    if (bus.pix_valid) begin
      if (exp_pix.size() == 0) chk("pix_unexp", 1, 0);
      else begin
        ep = exp_pix.pop_front();
        chk("pix_dat", {bus.pix_id, bus.pix_x, bus.pix_y}, ep);
      end
    end
    if (bus.done) begin
      chk("done_order", bus.pix_valid, 0);
      if (exp_done.size() == 0) chk("done_unexp", 1, 0);
      else begin
        ed = exp_done.pop_front();
        chk("done_dat", {bus.done_id, bus.done_cnt, bus.err}, ed);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    bus.req0 = 1'b0; bus.tri_0 = '0;
    bus.req1 = 1'b0; bus.tri_1 = '0;
    bus.busy = 1'b0; bus.po = 1'b0; bus.xo = '0; bus.yo = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_done(input int lim, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.done && cyc < lim);
    chk("done_seen", bus.done, 1);
  endtask

  // Plays one job as requester + rasterizer. lim<0: full job; lim>=0: stop after lim pixels, busy left high.
  task automatic serve(input bit exp_id, input logic [17:0] t, input bit keep, input bit stray,
                       input int lim, input int max_gap);
    int waited;
    int n;
    int c;
    waited = 0;
    if (stray) begin
      bus.po = 1'b1; bus.xo = 3'd6; bus.yo = 3'd1;
    end
    do begin
      @(negedge clk);
      waited++;
    end while (!(bus.ack0 || bus.ack1) && waited < 60);
    chk("ack_seen", bus.ack0 | bus.ack1, 1);
    chk("ack_id", {bus.ack1, bus.ack0}, exp_id ? 2'b10 : 2'b01);
    if (max_gap > 0) chk("ack_gap", waited <= max_gap, 1);
    @(posedge clk); #1;
    if (!keep) begin
      bus.req0 = 1'b0; bus.req1 = 1'b0;
    end
    for (int v = 0; v < 3; v++) begin
      @(negedge clk);
      chk("nt", bus.nt, v == 0);
      chk("vtx", {bus.xi, bus.yi}, t[17-6*v -: 6]);
      chk("ack_load", bus.ack0 | bus.ack1, 0);
    end
    @(posedge clk); #1;
    bus.po = 1'b0; bus.busy = 1'b1;
    n = 0;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        if (in_tri(t, x, y) && (lim < 0 || n < lim)) begin
          @(posedge clk); #1;
          bus.po = 1'b1; bus.xo = x[2:0]; bus.yo = y[2:0];
          exp_pix.push_back({exp_id, x[2:0], y[2:0]});
          n++;
        end
      end
    end
    if (lim < 0) begin
      @(posedge clk); #1;
      bus.po = 1'b0; bus.busy = 1'b0; bus.xo = '0; bus.yo = '0;
      exp_done.push_back({exp_id, 7'(n), 1'b0});
      wait_done(10, c);
      chk("done_lat", c, 2);
    end
  endtask

  initial begin
    int c;
    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_outs", {bus.ack0, bus.ack1, bus.nt, bus.xi, bus.yi, bus.pix_valid, bus.pix_id,
                     bus.pix_x, bus.pix_y, bus.done, bus.done_id, bus.done_cnt, bus.err}, 0);

    // Single job from requester 0
    @(posedge clk); #1;
    bus.req0 = 1'b1; bus.tri_0 = T_A;
    serve(1'b0, T_A, 1'b0, 1'b0, -1, 0);

    // Stray po in IDLE and LOAD states must not be forwarded or counted
    @(posedge clk); #1;
    bus.po = 1'b1; bus.xo = 3'd2; bus.yo = 3'd2;
    repeat (2) @(posedge clk);
    #1 bus.req0 = 1'b1; bus.tri_0 = T_B;
    serve(1'b0, T_B, 1'b0, 1'b1, -1, 0);

    // Tie from reset: 0,1,0,1 with back-to-back grants
    do_reset();
    bus.req0 = 1'b1; bus.tri_0 = T_A;
    bus.req1 = 1'b1; bus.tri_1 = T_B;
    for (int j = 0; j < 4; j++)
      serve(j[0], j[0] ? T_B : T_A, j < 3, 1'b0, -1, (j == 0) ? 0 : 1);

    // Watchdog abort with busy stuck high, then blocked grant and late po
    do_reset();
    @(posedge clk); #1;
    bus.req0 = 1'b1; bus.tri_0 = T_A;
    serve(1'b0, T_A, 1'b0, 1'b0, 0, 0);
    exp_done.push_back({1'b0, 7'd0, 1'b1});
    wait_done(TO + 10, c);
    chk("wdog_lat", c, TO + 1);
    bus.req1 = 1'b1; bus.tri_1 = T_B;
    bus.po = 1'b1; bus.xo = 3'd5; bus.yo = 3'd5;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("blk_ack", bus.ack0 | bus.ack1, 0);
    end
    @(posedge clk); #1;
    bus.busy = 1'b0; bus.po = 1'b0; bus.xo = '0; bus.yo = '0;
    serve(1'b1, T_B, 1'b0, 1'b0, -1, 1);

    // Reset in the middle of RUN after 3 pixels
    do_reset();
    @(posedge clk); #1;
    bus.req0 = 1'b1; bus.tri_0 = T_A;
    serve(1'b0, T_A, 1'b0, 1'b0, 3, 0);
    @(posedge clk); #1;
    reset = 1'b1; bus.po = 1'b0; bus.busy = 1'b0; bus.xo = '0; bus.yo = '0;
    @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_outs", {bus.ack0, bus.ack1, bus.nt, bus.xi, bus.yi, bus.pix_valid, bus.pix_id,
                         bus.pix_x, bus.pix_y, bus.done, bus.done_id, bus.done_cnt, bus.err}, 0);
    chk("rst_mid_pixq", exp_pix.size(), 0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    bus.req0 = 1'b1; bus.tri_0 = T_B;
    serve(1'b0, T_B, 1'b0, 1'b0, -1, 0);

    repeat (5) @(negedge clk);
    chk("pixq_empty", exp_pix.size(), 0);
    chk("doneq_empty", exp_done.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: still running at %0t, want finish before it", $time);
    $fatal(1);
  end

endmodule
